// File: rtl/uart_packet_tx_if.sv
// Packet-to-UART handshake bundle: the upstream formatter drives the send
// strobe and the four packet bytes, the transmitter returns the line and
// its status flags.
interface uart_packet_tx_if;
    logic       send;
    logic [7:0] tx_data1;
    logic [7:0] tx_data2;
    logic [7:0] tx_data3;
    logic [7:0] tx_data4;
    logic       tx;
    logic       busy;
    logic       done;

    // Packet source side (formatter / testbench)
    modport master (
        output send, tx_data1, tx_data2, tx_data3, tx_data4,
        input  tx, busy, done
    );

    // Transmitter side
    modport slave (
        input  send, tx_data1, tx_data2, tx_data3, tx_data4,
        output tx, busy, done
    );
endinterface

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: serialises the four-byte score packet (board ID, then
// points MSB..LSB) onto one 8N1 UART line, LSB first, frames back-to-back.
// Optional build macro PACKET_CHECKSUM_EN appends a fifth frame carrying the
// XOR of the four latched bytes.
// DIVISOR = CLK_HZ/BAUD must be at least 2.
module uart_packet_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic             clk,
    input  logic             rst,
    uart_packet_tx_if.slave  bus
);
    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

`ifdef PACKET_CHECKSUM_EN
    localparam int NUM_FRAMES = 5;
`else
    localparam int NUM_FRAMES = 4;
`endif
    localparam int FRM_W = $clog2(NUM_FRAMES);

    localparam logic [CNT_W-1:0] BIT_END    = CNT_W'(DIVISOR - 1);
    localparam logic [FRM_W-1:0] LAST_FRAME = FRM_W'(NUM_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                       state;
    logic [CNT_W-1:0]             baud_cnt;
    logic [2:0]                   bit_idx;
    logic [FRM_W-1:0]             byte_idx;
    // Holding register; frames[0] is always the frame on the wire, later
    // frames move down one slot at each stop bit.
    logic [NUM_FRAMES-1:0][7:0]   frames;
    logic                         tx_q;
    logic                         busy_q;
    logic                         done_q;

    logic                         bit_end;
    logic [2:0]                   next_bit;

    assign bit_end  = (baud_cnt == BIT_END);
    assign next_bit = bit_idx + 3'd1;

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    // Packet FSM: baud timing, bit/frame sequencing and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    byte_idx <= '0;
                    // A send in the done cycle lands here too, so packets can
                    // run back-to-back with no idle bit between them.
                    if (bus.send) begin
                        frames[0] <= bus.tx_data1;
                        frames[1] <= bus.tx_data2;
                        frames[2] <= bus.tx_data3;
                        frames[3] <= bus.tx_data4;
`ifdef PACKET_CHECKSUM_EN
                        frames[4] <= bus.tx_data1 ^ bus.tx_data2 ^
                                     bus.tx_data3 ^ bus.tx_data4;
`endif
                        state  <= START;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= frames[0][0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= next_bit;
                            tx_q    <= frames[0][next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        if (byte_idx == LAST_FRAME) begin
                            // Last stop bit finished: drop busy and pulse done
                            // in the first idle cycle.
                            state    <= IDLE;
                            tx_q     <= 1'b1;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            byte_idx <= '0;
                        end else begin
                            state    <= START;
                            tx_q     <= 1'b0;
                            byte_idx <= byte_idx + FRM_W'(1);
                            frames   <= {8'h00, frames[NUM_FRAMES-1:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx at DIVISOR=16: directed packets with a UART
// receiver monitor that pops expected bytes from a scoreboard queue.
module tb_uart_packet_tx;
    localparam int DIV = 16;
`ifdef PACKET_CHECKSUM_EN
    localparam int  NF    = 5;
    localparam bit  CK_EN = 1'b1;
`else
    localparam int  NF    = 4;
    localparam bit  CK_EN = 1'b0;
`endif
    localparam int PKT_LEN = NF * 10 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_packet_tx_if bus ();

    uart_packet_tx #(.CLK_HZ(16), .BAUD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bit time of the line: first sample is the bit value, the rest must match it
    task automatic sample_bit(output logic v, inout bit ok, inout bit ab);
        @(negedge clk);
        if (rst) ab = 1'b1;
        v = bus.tx;
        for (int s = 1; s < DIV; s++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
            if (bus.tx !== v) ok = 1'b0;
        end
    endtask

    logic [7:0] rx_byte;
    logic [7:0] rx_exp;
    logic       rx_v;
    bit         rx_ok;
    bit         rx_ab;

    // Receiver monitor: decodes each frame and scores it against the queue
    always begin : rx_monitor
        @(negedge clk);
        if (!rst && bus.tx === 1'b0) begin
            rx_ok = 1'b1;
            rx_ab = 1'b0;
            for (int s = 1; s < DIV; s++) begin
                @(negedge clk);
                if (rst) rx_ab = 1'b1;
                if (bus.tx !== 1'b0) rx_ok = 1'b0;
            end
            for (int b = 0; b < 8; b++) begin
                sample_bit(rx_v, rx_ok, rx_ab);
                rx_byte[b] = rx_v;
            end
            sample_bit(rx_v, rx_ok, rx_ab);
            if (rx_v !== 1'b1) rx_ok = 1'b0;
            if (!rx_ab) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected frame: got %0h, expected no frame at %0t", rx_byte, $time);
                end else begin
                    rx_exp = exp_q.pop_front();
                    check("frame byte", 32'(rx_byte), 32'(rx_exp));
                    check("frame timing/stop", 32'(rx_ok), 32'd1);
                end
            end
        end
    end

    // Called at a negedge; drives a one-cycle send and checks the start-bit latency
    task automatic start_packet(input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4,
                                input logic [7:0] ck);
        bus.tx_data1 = b1;
        bus.tx_data2 = b2;
        bus.tx_data3 = b3;
        bus.tx_data4 = b4;
        bus.send     = 1'b1;
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
        if (CK_EN) exp_q.push_back(ck);
        @(negedge clk);
        bus.send = 1'b0;
        check("start bit latency", 32'(bus.tx), 32'd0);
        check("busy rise", 32'(bus.busy), 32'd1);
    endtask

    // Counts busy cycles until it falls; returns in the done cycle
    task automatic wait_done(input int start_n, input string tag);
        int n = start_n;
        while (bus.busy === 1'b1 && n < 4000) begin
            @(negedge clk);
            if (bus.busy === 1'b1) n++;
        end
        if (n >= 4000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: busy still high after %0d cycles", tag, n);
        end
        check({tag, " busy length"}, 32'(n), 32'(PKT_LEN));
        check({tag, " done pulse"}, 32'(bus.done), 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit seen;
        bus.send     = 1'b0;
        bus.tx_data1 = '0;
        bus.tx_data2 = '0;
        bus.tx_data3 = '0;
        bus.tx_data4 = '0;

        // Reset values, held and after release
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset tx", 32'(bus.tx), 32'd1);
            check("reset busy", 32'(bus.busy), 32'd0);
            check("reset done", 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) seen = 1'b1;
        end
        check("idle after reset", 32'(seen), 32'd0);

        // Basic packet, with an input change and an ignored send while busy
        start_packet(8'h02, 8'h00, 8'h12, 8'h34, 8'h24);
        repeat (99) @(negedge clk);
        bus.tx_data2 = 8'hFF;
        bus.send     = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        wait_done(101, "pkt1");

        // Back-to-back: send in the done cycle
        start_packet(8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h00);
        check("done single cycle", 32'(bus.done), 32'd0);
        wait_done(1, "pkt2");
        @(negedge clk);
        check("idle tx", 32'(bus.tx), 32'd1);
        check("idle done low", 32'(bus.done), 32'd0);
        repeat (5) @(negedge clk);

        // Reset during the data bits of the second frame
        start_packet(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        repeat (199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset tx", 32'(bus.tx), 32'd1);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        check("no resume after reset", 32'(seen), 32'd0);
        repeat (200) @(negedge clk);
        exp_q.delete();

        // Fresh full packet after the reset
        start_packet(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        wait_done(1, "pkt4");
        repeat (20) @(negedge clk);
        check("all frames received", 32'(exp_q.size()), 32'd0);
        check("final idle tx", 32'(bus.tx), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
